decode: RTL and testbench
=========================

# decode

Decode stage of the RV32I pipeline, directly downstream of fetch. Accepts a (pc, instruction) beat over a valid/ready handshake and extracts register indices, opcode/funct fields and the sign-extended immediate. Presents them to execute in a registered output stage with a one-entry skid buffer, so `ready_o` is a pure register output. Supports downstream stall and branch-redirect flush.

## Interface
- `DWIDTH`, 32, instruction width.
- `AWIDTH`, 32, PC width.
- `IMEM_BASE_ADDR`, 32'h01000000, reset value of `pc_o`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_i`  in  AWIDTH  PC of the incoming beat.
- `insn_i`  in  DWIDTH  instruction of the incoming beat.
- `valid_i`  in  1  incoming beat valid.
- `ready_o`  out  1  decode can accept; a transfer occurs when `valid_i && ready_o`.
- `stall_i`  in  1  execute cannot consume this cycle.
- `flush_i`  in  1  kill all held and incoming beats.
- `valid_o`  out  1  output beat valid; consumed when `valid_o && !stall_i`.
- `pc_o`  out  AWIDTH  PC of the output beat.
- `insn_o`  out  DWIDTH  raw instruction of the output beat.
- `opcode_o`  out  7  instruction bits [6:0].
- `rd_o`  out  5  instruction bits [11:7].
- `funct3_o`  out  3  instruction bits [14:12].
- `rs1_o`  out  5  instruction bits [19:15].
- `rs2_o`  out  5  instruction bits [24:20].
- `funct7_o`  out  7  instruction bits [31:25].
- `imm_o`  out  32  sign-extended immediate.
- `illegal_o`  out  1  unsupported encoding.

## Operation
- Decoding is combinational on the accepted beat. Decoded fields are stored in the output register or the skid register, never recomputed at the output.
- Immediate selection by opcode:
  - I-type for 0x13, 0x03, 0x67, 0x73, 0x0F: sext(insn[31:20]).
  - S-type for 0x23: sext({insn[31:25], insn[11:7]}).
  - B-type for 0x63: sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}).
  - U-type for 0x37, 0x17: {insn[31:12], 12'b0}.
  - J-type for 0x6F: sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}).
  - R-type 0x33 and all other opcodes: imm = 0.
- `illegal_o` = 1 when opcode is not one of the 11 listed above or insn[1:0] != 2'b11. Field outputs still carry the raw bit slices.
- State: output register (OUT, with `valid_o`) and skid register (SKID, with `skid_valid`). `ready_o` = !`skid_valid`, registered.
- Per-cycle update, with the first matching rule applied:
  - `flush_i`: `valid_o` <= 0, `skid_valid` <= 0, `ready_o` <= 1. A beat offered this cycle is dropped.
  - SKID full and OUT consumed (or OUT empty): OUT <= SKID, `skid_valid` <= 0.
  - Transfer in, and OUT empty or OUT consumed: OUT <= new beat, `valid_o` <= 1.
  - Transfer in while OUT valid and stalled: SKID <= new beat, `skid_valid` <= 1.
  - OUT consumed with no replacement: `valid_o` <= 0.
  - Otherwise: hold all state.
- While `valid_o && stall_i`, every output is stable.
- Beats are never lost, duplicated or reordered.

## Timing
- Reset (asynchronous, immediate), with outputs equal to a decoded NOP:
  - `valid_o` = 0, `ready_o` = 1, `skid_valid` = 0, `pc_o` = `IMEM_BASE_ADDR`.
  - `insn_o` = 32'h00000013, `opcode_o` = 7'h13.
  - All other fields = 0, `imm_o` = 0, `illegal_o` = 0.
- Reset asserted mid-operation discards OUT and SKID contents.
- Latency: a beat accepted at edge N appears on outputs after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle while `stall_i` = 0.
- `ready_o` falls the cycle after a beat enters SKID. It rises the cycle after SKID drains or after a flush.
- `stall_i` has no effect while `valid_o` = 0.
- `flush_i` together with `stall_i`: flush wins.

## Test plan
- **Reset:** assert `rst` asynchronously mid-stream with `valid_o` = 1.
  - Outputs switch before the next edge to `valid_o` = 0, `ready_o` = 1, `pc_o` = 0x01000000, `insn_o` = 0x00000013.
- **Basic decode:** pc 0x01000000, insn 0x00500093 (addi x1,x0,5).
  - Next cycle: `valid_o` = 1, `opcode_o` = 0x13, `rd_o` = 1, `rs1_o` = 0, `funct3_o` = 0, `imm_o` = 0x00000005.
- **Immediate formats:**
  - 0xFE20AE23 (sw x2,-4(x1)) gives `imm_o` = 0xFFFFFFFC, `rs1_o` = 1, `rs2_o` = 2.
  - 0x00208863 (beq x1,x2,+16) gives `imm_o` = 0x00000010.
  - 0x123452B7 (lui x5) gives `imm_o` = 0x12345000, `rd_o` = 5.
  - 0x0000006F (jal x0,0) gives `imm_o` = 0.
- **Stall/skid:** with X on the output, hold `stall_i` = 1 and offer beats A then B.
  - A enters SKID; `ready_o` = 0 next cycle; B is held upstream.
  - On releasing the stall, the sequence is X, then A, then B on consecutive cycles.
  - `ready_o` = 1 the cycle after A moves to OUT; no loss or duplication.
- **Flush:** pulse `flush_i` with OUT and SKID full and a beat offered.
  - Next cycle: `valid_o` = 0, `ready_o` = 1.
  - The offered beat never appears; the next beat decodes normally.
- **Illegal:**
  - insn 0xFFFFFFFF gives `illegal_o` = 1, `imm_o` = 0.
  - insn 0x00000000 gives `illegal_o` = 1 (bits [1:0] = 00).
  - insn 0x00000033 gives `illegal_o` = 0, `imm_o` = 0.

Source files
------------

// File: rtl/decode.sv
// RV32I decode stage: registered output with a one-entry skid buffer so the
// upstream ready is a plain flop; supports downstream stall and flush.
module decode #(
  parameter int unsigned         DWIDTH         = 32,
  parameter int unsigned         AWIDTH         = 32,
  parameter logic [AWIDTH-1:0]   IMEM_BASE_ADDR = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_FENCE  = 7'h0F,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              illegal;
  } beat_t;

  beat_t dec;
  beat_t out_q;
  beat_t skid_q;
  logic  out_valid_q;
  logic  skid_valid_q;
  logic  ready_q;

  logic  legal_op;
  logic  xfer;
  logic  consumed;

  always_comb begin
    dec        = '0;
    legal_op   = 1'b1;
    dec.pc     = pc_i;
    dec.insn   = insn_i;
    dec.opcode = insn_i[6:0];
    dec.rd     = insn_i[11:7];
    dec.funct3 = insn_i[14:12];
    dec.rs1    = insn_i[19:15];
    dec.rs2    = insn_i[24:20];
    dec.funct7 = insn_i[31:25];
    case (insn_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
        dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
      OP_STORE:
        dec.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      OP_BRANCH:
        dec.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        dec.imm = {insn_i[31:12], 12'b0};
      OP_JAL:
        dec.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      OP_REG:
        dec.imm = '0;
      default: begin
        dec.imm  = '0;
        legal_op = 1'b0;
      end
    endcase
    dec.illegal = !legal_op || (insn_i[1:0] != 2'b11);
  end

  assign xfer     = valid_i && ready_q;
  assign consumed = out_valid_q && !stall_i;

  // Skid can only be full while OUT is full, so draining it takes priority
  // and blocks new transfers (ready is low whenever skid is occupied).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q         <= '0;
      out_q.pc      <= IMEM_BASE_ADDR;
      out_q.insn    <= DWIDTH'(32'h00000013);
      out_q.opcode  <= OP_IMM;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
    end else if (flush_i) begin
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
    end else if (skid_valid_q && (consumed || !out_valid_q)) begin
      out_q         <= skid_q;
      out_valid_q   <= 1'b1;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
    end else if (xfer && (!out_valid_q || consumed)) begin
      out_q         <= dec;
      out_valid_q   <= 1'b1;
    end else if (xfer) begin
      skid_q        <= dec;
      skid_valid_q  <= 1'b1;
      ready_q       <= 1'b0;
    end else if (consumed) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = out_valid_q;
  assign pc_o      = out_q.pc;
  assign insn_o    = out_q.insn;
  assign opcode_o  = out_q.opcode;
  assign rd_o      = out_q.rd;
  assign funct3_o  = out_q.funct3;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct7_o  = out_q.funct7;
  assign imm_o     = out_q.imm;
  assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus a randomized stream
// compared against a queue-based occupancy model and an arithmetic decoder.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, insn_i;
  logic        valid_i, stall_i, flush_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;
  logic        illegal_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef logic [128:0] vec_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } beat_t;
  beat_t q[$];

  vec_t obs, exp_v;
  assign obs = {pc_o, insn_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, imm_o, illegal_o};

  decode #(.DWIDTH(32), .AWIDTH(32), .IMEM_BASE_ADDR(32'h01000000)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .insn_i(insn_i), .valid_i(valid_i),
    .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // Reference decoder built from shifts/masks and signed arithmetic.
  function automatic vec_t ref_dec(input logic [31:0] pc, input logic [31:0] insn);
    longint x, v;
    int op;
    logic legal;
    x = insn;
    op = int'(x & 127);
    v = 0;
    legal = 1'b1;
    case (op)
      'h13, 'h03, 'h67, 'h73, 'h0F: begin
        v = x >> 20;
        if (v >= 2048) v = v - 4096;
      end
      'h23: begin
        v = ((x >> 25) << 5) | ((x >> 7) & 31);
        if (v >= 2048) v = v - 4096;
      end
      'h63: begin
        v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
        if (v >= 4096) v = v - 8192;
      end
      'h37, 'h17: v = x & 64'hFFFFF000;
      'h6F: begin
        v = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
        if (v >= 1048576) v = v - 2097152;
      end
      'h33: v = 0;
      default: legal = 1'b0;
    endcase
    if ((x & 3) != 3) legal = 1'b0;
    return {pc, insn, 7'(x), 5'(x >> 7), 3'(x >> 12), 5'(x >> 15), 5'(x >> 20), 7'(x >> 25), 32'(v), !legal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic st, input logic fl);
    valid_i = v; pc_i = pc; insn_i = insn; stall_i = st; flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    q.delete();
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    exp_v = ref_dec(32'h01000000, 32'h00000013);
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || obs !== exp_v) begin
      n_err++; $display("FAIL reset_initial v=%b r=%b got=%h exp=%h", valid_o, ready_o, obs, exp_v);
    end
    tick(); rst = 1'b0; tick();
    drive(1'b1, 32'h01000040, 32'h00A00113, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || insn_o !== 32'h00A00113) begin
      n_err++; $display("FAIL reset_prefill v=%b insn=%h exp v=1 insn=00a00113", valid_o, insn_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'h01000000 || insn_o !== 32'h00000013 || obs !== exp_v) begin
      n_err++; $display("FAIL reset_async v=%b r=%b pc=%h insn=%h exp v=0 r=1 pc=01000000 insn=00000013", valid_o, ready_o, pc_o, insn_o);
    end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 32'h01000000, 32'h00500093, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || opcode_o !== 7'h13 || rd_o !== 5'd1 || rs1_o !== 5'd0 || funct3_o !== 3'd0 || imm_o !== 32'h5 || pc_o !== 32'h01000000) begin
      n_err++; $display("FAIL basic_addi v=%b op=%h rd=%0d rs1=%0d f3=%0d imm=%h exp v=1 op=13 rd=1 rs1=0 f3=0 imm=00000005", valid_o, opcode_o, rd_o, rs1_o, funct3_o, imm_o);
    end
  endtask

  task automatic test_imm_formats();
    logic [31:0] insns [4] = '{32'hFE20AE23, 32'h00208863, 32'h123452B7, 32'h0000006F};
    logic [31:0] imms  [4] = '{32'hFFFFFFFC, 32'h00000010, 32'h12345000, 32'h00000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h01000100 + 32'(i * 4), insns[i], 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || imm_o !== imms[i] || illegal_o !== 1'b0) begin
        n_err++; $display("FAIL imm_fmt%0d v=%b imm=%h ill=%b exp imm=%h", i, valid_o, imm_o, illegal_o, imms[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (rs1_o !== 5'd1 || rs2_o !== 5'd2) begin
          n_err++; $display("FAIL imm_sw_regs rs1=%0d rs2=%0d exp 1 2", rs1_o, rs2_o);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (rd_o !== 5'd5) begin
          n_err++; $display("FAIL imm_lui_rd rd=%0d exp 5", rd_o);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_stall_skid();
    logic [31:0] ix = 32'h00100093, ia = 32'h00200113, ib = 32'h00300193;
    do_reset();
    drive(1'b1, 32'h10, ix, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h14, ia, 1'b1, 1'b0); tick();
    n_cmp++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || insn_o !== ix) begin
      n_err++; $display("FAIL skid_fill r=%b v=%b insn=%h exp r=0 v=1 insn=%h", ready_o, valid_o, insn_o, ix);
    end
    drive(1'b1, 32'h18, ib, 1'b1, 1'b0); tick();
    n_cmp++;
    if (ready_o !== 1'b0 || insn_o !== ix || pc_o !== 32'h10) begin
      n_err++; $display("FAIL skid_hold r=%b insn=%h pc=%h exp r=0 insn=%h pc=00000010", ready_o, insn_o, pc_o, ix);
    end
    drive(1'b1, 32'h18, ib, 1'b0, 1'b0); tick();
    n_cmp++;
    if (valid_o !== 1'b1 || insn_o !== ia || pc_o !== 32'h14 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL skid_drain v=%b insn=%h pc=%h r=%b exp v=1 insn=%h pc=00000014 r=1", valid_o, insn_o, pc_o, ready_o, ia);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || insn_o !== ib || pc_o !== 32'h18) begin
      n_err++; $display("FAIL skid_b v=%b insn=%h pc=%h exp v=1 insn=%h", valid_o, insn_o, pc_o, ib);
    end
    tick();
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL skid_empty v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h20, 32'h00100093, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h24, 32'h00200113, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h28, 32'h00300193, 1'b1, 1'b1); tick();
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush_state v=%b r=%b exp v=0 r=1", valid_o, ready_o);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_drop v=%b insn=%h exp v=0", valid_o, insn_o);
    end
    drive(1'b1, 32'h2C, 32'h00400213, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    exp_v = ref_dec(32'h2C, 32'h00400213);
    n_cmp++;
    if (valid_o !== 1'b1 || obs !== exp_v) begin
      n_err++; $display("FAIL flush_next v=%b got=%h exp=%h", valid_o, obs, exp_v);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] insns [3] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000033};
    logic        ills  [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40, insns[i], 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (illegal_o !== ills[i] || imm_o !== 32'h0 || insn_o !== insns[i]) begin
        n_err++; $display("FAIL illegal%0d ill=%b imm=%h insn=%h exp ill=%b imm=0", i, illegal_o, imm_o, insn_o, ills[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] r, ins;
    logic        v, st, fl;
    int unsigned occ;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      n_cmp++;
      if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2) ||
          (q.size() > 0 && obs !== ref_dec(q[0].pc, q[0].insn))) begin
        n_err++;
        $display("FAIL random c=%0d v=%b r=%b occ=%0d got=%h exp=%h", c, valid_o, ready_o, q.size(), obs,
                 (q.size() > 0) ? ref_dec(q[0].pc, q[0].insn) : '0);
      end
      r   = $urandom();
      ins = ($urandom_range(0, 4) == 0) ? $urandom() : {r[31:7], ops[$urandom_range(0, 11)]};
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 24) == 0);
      drive(v, $urandom(), ins, st, fl);
      @(posedge clk);
      occ = q.size();
      if (fl) q.delete();
      else begin
        if (occ > 0 && !st) void'(q.pop_front());
        if (v && occ < 2) q.push_back('{pc: pc_i, insn: insn_i});
      end
      #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #3;
    test_reset();
    test_basic();
    test_imm_formats();
    test_stall_skid();
    test_flush();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
